mem_stage_ctrl: RTL and testbench

- MEM-stage controller of the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register.
- Consumes the EX/MEM bundle and runs 64-bit load/store transactions on a valid/ready data-memory port.
- Stalls upstream while a transaction is in flight, resolves branches (branch & zero), and registers the MEM/WB outputs.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/mem_timeout_ctr.sv | 30 +++
 rtl/mem_stage_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the MEM stage: FSM state encoding, default widths
// and the EX/MEM, MEM/WB control bundles.
package pipe_pkg;

  localparam int DEF_XLEN = 64;
  localparam int DEF_PCW  = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  typedef struct packed {
    logic valid;
    logic zero;
    logic branch;
    logic MemRead;
    logic MemWrite;
    logic MemtoReg;
    logic regwrite;
  } exm_ctrl_t;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic MemtoReg;
  } memwb_ctrl_t;

  // Controls captured when a memory op is accepted and held until it retires.
  typedef struct packed {
    logic we;
    logic regwrite;
    logic MemtoReg;
  } lat_ctrl_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog for an in-flight data-memory transaction: cleared on entry to REQ,
// counts every in-flight cycle, flags expiry on the TIMEOUT_CYCLES-th one.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic active_i,
  output logic expired_o
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (active_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = active_i & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs loads/stores on a valid/ready dmem port, stalls
// upstream while busy, resolves branches, owns MEM/WB. Option: MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int XLEN           = pipe_pkg::DEF_XLEN,
  parameter int PCW            = pipe_pkg::DEF_PCW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exm_valid,
  input  logic [XLEN-1:0] exm_alu_data,
  input  logic [XLEN-1:0] exm_rs2_data,
  input  logic [4:0]      exm_rd,
  input  logic [PCW-1:0]  exm_pc_branch,
  input  logic            exm_zero,
  input  logic            exm_branch,
  input  logic            exm_MemRead,
  input  logic            exm_MemWrite,
  input  logic            exm_MemtoReg,
  input  logic            exm_regwrite,
  output logic            mem_stall,
  output logic            pc_src,
  output logic [PCW-1:0]  pc_branch_target,
  output logic            flush,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_regwrite,
  output logic            wb_MemtoReg,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_alu_data,
  output logic [XLEN-1:0] wb_read_data,
  output logic            mem_err
);

  import pipe_pkg::*;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [4:0]      lat_rd_q, lat_rd_d;
  lat_ctrl_t       lat_q, lat_d;
  memwb_ctrl_t     wb_q, wb_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_alu_q, wb_alu_d, wb_rdata_q, wb_rdata_d;
  logic            mem_err_q, mem_err_d;

  exm_ctrl_t exm_c;
  logic      mem_op, st_done, ld_done, done, abort, tmo_expired, stall_raw;

  assign exm_c = '{valid: exm_valid, zero: exm_zero, branch: exm_branch,
                   MemRead: exm_MemRead, MemWrite: exm_MemWrite,
                   MemtoReg: exm_MemtoReg, regwrite: exm_regwrite};

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   ((state_q == IDLE) & mem_op),
    .active_i  (state_q != IDLE),
    .expired_o (tmo_expired)
  );
`else
  // Watchdog absent: wait for the memory indefinitely.
  assign tmo_expired = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    mem_op  = exm_c.valid & (exm_c.MemRead | exm_c.MemWrite);
    st_done = (state_q == REQ) & dmem_req_ready & lat_q.we;
    ld_done = (state_q == WAIT_RSP) & dmem_rsp_valid;
    done    = st_done | ld_done;
    abort   = tmo_expired & ~done;

    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_rd_d   = lat_rd_q;
    lat_d      = lat_q;
    wb_d       = '0;
    wb_rd_d    = wb_rd_q;
    wb_alu_d   = wb_alu_q;
    wb_rdata_d = wb_rdata_q;
    mem_err_d  = abort;
    stall_raw  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          addr_d     = exm_alu_data;
          wdata_d    = exm_rs2_data;
          lat_rd_d   = exm_rd;
          // A load with MemWrite also set is still a load.
          lat_d      = '{we: ~exm_c.MemRead, regwrite: exm_c.regwrite, MemtoReg: exm_c.MemtoReg};
          state_d    = REQ;
          stall_raw  = 1'b1;
        end else begin
          wb_d       = '{valid: exm_c.valid, regwrite: exm_c.regwrite, MemtoReg: exm_c.MemtoReg};
          wb_rd_d    = exm_rd;
          wb_alu_d   = exm_alu_data;
          wb_rdata_d = '0;
        end
      end
      REQ: begin
        if (dmem_req_ready) state_d = lat_q.we ? IDLE : WAIT_RSP;
        stall_raw = ~st_done;
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) state_d = IDLE;
        stall_raw = ~ld_done;
      end
      default: state_d = IDLE;
    endcase

    if (done | abort) begin
      wb_d       = '{valid: 1'b1, regwrite: lat_q.regwrite & ~abort, MemtoReg: lat_q.MemtoReg};
      wb_rd_d    = lat_rd_q;
      wb_alu_d   = addr_q;
      wb_rdata_d = ld_done ? dmem_rdata : '0;
    end
    if (abort) begin
      state_d   = IDLE;
      stall_raw = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_rd_q   <= '0;
      lat_q      <= '0;
      wb_q       <= '0;
      wb_rd_q    <= '0;
      wb_alu_q   <= '0;
      wb_rdata_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_rd_q   <= lat_rd_d;
      lat_q      <= lat_d;
      wb_q       <= wb_d;
      wb_rd_q    <= wb_rd_d;
      wb_alu_q   <= wb_alu_d;
      wb_rdata_q <= wb_rdata_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign mem_stall        = rst_n & stall_raw;
  assign pc_src           = rst_n & (state_q == IDLE) & exm_c.valid & exm_c.branch & exm_c.zero;
  assign flush            = pc_src;
  assign pc_branch_target = exm_pc_branch;
  assign dmem_req_valid   = rst_n & (state_q == REQ);
  assign dmem_we          = lat_q.we;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;

  assign wb_valid     = wb_q.valid;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_MemtoReg  = wb_q.MemtoReg;
  assign wb_rd        = wb_rd_q;
  assign wb_alu_data  = wb_alu_q;
  assign wb_read_data = wb_rdata_q;
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: ALU, store, backpressured load, branch,
// reset mid-load; watchdog abort when built with MEM_TIMEOUT_EN.
module tb_mem_stage_ctrl;

  localparam int XLEN = 64;
  localparam int PCW  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            exm_valid, exm_zero, exm_branch, exm_MemRead, exm_MemWrite;
  logic            exm_MemtoReg, exm_regwrite;
  logic [XLEN-1:0] exm_alu_data, exm_rs2_data;
  logic [4:0]      exm_rd;
  logic [PCW-1:0]  exm_pc_branch;
  logic            mem_stall, pc_src, flush;
  logic [PCW-1:0]  pc_branch_target;
  logic            dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic            wb_valid, wb_regwrite, wb_MemtoReg, mem_err;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_alu_data, wb_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_ctrl #(.XLEN(XLEN), .PCW(PCW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .exm_valid(exm_valid), .exm_alu_data(exm_alu_data), .exm_rs2_data(exm_rs2_data),
    .exm_rd(exm_rd), .exm_pc_branch(exm_pc_branch), .exm_zero(exm_zero),
    .exm_branch(exm_branch), .exm_MemRead(exm_MemRead), .exm_MemWrite(exm_MemWrite),
    .exm_MemtoReg(exm_MemtoReg), .exm_regwrite(exm_regwrite),
    .mem_stall(mem_stall), .pc_src(pc_src), .pc_branch_target(pc_branch_target),
    .flush(flush), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_rd(wb_rd), .wb_alu_data(wb_alu_data), .wb_read_data(wb_read_data),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bubble();
    exm_valid = 0; exm_zero = 0; exm_branch = 0; exm_MemRead = 0; exm_MemWrite = 0;
    exm_MemtoReg = 0; exm_regwrite = 0; exm_alu_data = '0; exm_rs2_data = '0;
    exm_rd = '0; exm_pc_branch = '0;
  endtask

  task automatic set_op(input logic rd_en, input logic wr_en, input logic m2r, input logic rw,
                        input logic [63:0] alu, input logic [63:0] rs2, input logic [4:0] rd);
    set_bubble();
    exm_valid = 1; exm_MemRead = rd_en; exm_MemWrite = wr_en; exm_MemtoReg = m2r;
    exm_regwrite = rw; exm_alu_data = alu; exm_rs2_data = rs2; exm_rd = rd;
  endtask

  initial begin
    rst_n = 0; dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = '0;
    set_bubble();
    #1;
    check_val("rst_wb_valid", wb_valid, 0);
    check_val("rst_req_valid", dmem_req_valid, 0);
    check_val("rst_stall", mem_stall, 0);
    check_val("rst_mem_err", mem_err, 0);
    tick(); tick();
    rst_n = 1;
    tick();

    // ALU op retires after one edge, no stall
    set_op(0, 0, 0, 1, 64'h2A, 64'h0, 5'd5);
    #1 check_val("alu_stall", mem_stall, 0);
    tick();
    check_val("alu_wb_valid", wb_valid, 1);
    check_val("alu_wb_alu", wb_alu_data, 64'h2A);
    check_val("alu_wb_rd", wb_rd, 5);
    check_val("alu_wb_regwrite", wb_regwrite, 1);
    check_val("alu_wb_rdata", wb_read_data, 0);
    set_bubble();

    // Store accepted in its first REQ cycle
    set_op(0, 1, 0, 0, 64'h1000, 64'hDEAD, 5'd0);
    #1 check_val("st_stall_idle", mem_stall, 1);
    check_val("st_req_idle", dmem_req_valid, 0);
    tick();
    dmem_req_ready = 1;
    #1 check_val("st_req_valid", dmem_req_valid, 1);
    check_val("st_we", dmem_we, 1);
    check_val("st_addr", dmem_addr, 64'h1000);
    check_val("st_wdata", dmem_wdata, 64'hDEAD);
    check_val("st_stall_done", mem_stall, 0);
    check_val("st_wb_bubble", wb_valid, 0);
    tick();
    dmem_req_ready = 0;
    check_val("st_wb_valid", wb_valid, 1);
    check_val("st_wb_alu", wb_alu_data, 64'h1000);
    set_bubble();
    #1 check_val("st_req_after", dmem_req_valid, 0);

    // Load with 3 cycles of backpressure, response 2 cycles after handshake
    set_op(1, 0, 1, 1, 64'h2000, 64'h0, 5'd7);
    #1 check_val("ld_stall_idle", mem_stall, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("ld_bp_req_valid", dmem_req_valid, 1);
      check_val("ld_bp_addr", dmem_addr, 64'h2000);
      check_val("ld_bp_we", dmem_we, 0);
      check_val("ld_bp_stall", mem_stall, 1);
      check_val("ld_bp_wb_valid", wb_valid, 0);
      tick();
    end
    dmem_req_ready = 1;
    #1 check_val("ld_hs_stall", mem_stall, 1);
    check_val("ld_hs_addr", dmem_addr, 64'h2000);
    tick();
    dmem_req_ready = 0;
    #1 check_val("ld_wait_req_valid", dmem_req_valid, 0);
    check_val("ld_wait_stall", mem_stall, 1);
    tick();
    dmem_rsp_valid = 1; dmem_rdata = 64'hCAFEF00D;
    #1 check_val("ld_rsp_stall", mem_stall, 0);
    tick();
    dmem_rsp_valid = 0; dmem_rdata = '0;
    check_val("ld_wb_valid", wb_valid, 1);
    check_val("ld_wb_rdata", wb_read_data, 64'hCAFEF00D);
    check_val("ld_wb_m2r", wb_MemtoReg, 1);
    check_val("ld_wb_rd", wb_rd, 7);
    check_val("ld_wb_regwrite", wb_regwrite, 1);
    set_bubble();

    // Both MemRead and MemWrite set behaves as a load
    set_op(1, 1, 1, 1, 64'h3000, 64'h77, 5'd9);
    tick();
    #1 check_val("rw_we", dmem_we, 0);
    dmem_req_ready = 1;
    #1 check_val("rw_hs_stall", mem_stall, 1);
    tick();
    dmem_req_ready = 0;
    dmem_rsp_valid = 1; dmem_rdata = 64'h1234;
    tick();
    dmem_rsp_valid = 0;
    check_val("rw_wb_rdata", wb_read_data, 64'h1234);
    set_bubble();

    // Branch resolution, taken and not taken
    exm_valid = 1; exm_branch = 1; exm_zero = 1; exm_pc_branch = 32'h80;
    #1 check_val("br_pc_src", pc_src, 1);
    check_val("br_flush", flush, 1);
    check_val("br_target", pc_branch_target, 32'h80);
    check_val("br_stall", mem_stall, 0);
    exm_zero = 0;
    #1 check_val("br_nt_pc_src", pc_src, 0);
    check_val("br_nt_flush", flush, 0);
    tick();
    set_bubble();

    // Reset while a load waits for its response
    set_op(1, 0, 1, 1, 64'h4000, 64'h0, 5'd4);
    tick();
    dmem_req_ready = 1;
    tick();
    dmem_req_ready = 0;
    #1 check_val("rs_pre_stall", mem_stall, 1);
    rst_n = 0;
    #1 check_val("rs_req_valid", dmem_req_valid, 0);
    check_val("rs_stall", mem_stall, 0);
    check_val("rs_wb_valid", wb_valid, 0);
    check_val("rs_wb_alu", wb_alu_data, 0);
    check_val("rs_pc_src", pc_src, 0);
    tick();
    rst_n = 1;
    set_bubble();
    dmem_rsp_valid = 1; dmem_rdata = 64'hBAD;
    tick();
    check_val("rs_late_wb_valid", wb_valid, 0);
    check_val("rs_late_rdata", wb_read_data, 0);
    set_op(0, 0, 0, 1, 64'h55, 64'h0, 5'd3);
    #1 check_val("rs_alu_stall", mem_stall, 0);
    tick();
    dmem_rsp_valid = 0; dmem_rdata = '0;
    check_val("rs_alu_wb_valid", wb_valid, 1);
    check_val("rs_alu_wb_alu", wb_alu_data, 64'h55);
    check_val("rs_alu_wb_rd", wb_rd, 3);
    check_val("rs_alu_rdata", wb_read_data, 0);
    set_bubble();
    tick();

`ifdef MEM_TIMEOUT_EN
    // Watchdog abort with ready never asserted (TIMEOUT_CYCLES = 4)
    set_op(0, 1, 0, 1, 64'h5000, 64'h99, 5'd6);
    tick();
    begin
      int cyc;
      cyc = 0;
      while (cyc < 10) begin
        cyc++;
        #1;
        if (!mem_stall) break;
        tick();
      end
      check_val("to_abort_cycle", cyc, 4);
    end
    tick();
    set_bubble();
    check_val("to_mem_err", mem_err, 1);
    check_val("to_wb_valid", wb_valid, 1);
    check_val("to_wb_regwrite", wb_regwrite, 0);
    check_val("to_req_valid", dmem_req_valid, 0);
    #1 check_val("to_stall", mem_stall, 0);
    tick();
    check_val("to_mem_err_pulse", mem_err, 0);
`else
    check_val("mem_err_tied", mem_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
